// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises one DBIT-wide word per request as start/data/stop bits.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | driving the start bit (low)
// DATA   | shifting out data bits, LSB first
// PARITY | driving the even-parity bit (UART_TX_PARITY_EN only)
// STOP   | driving STOP_BITS stop bits (high)
module uart_tx_ctrl #(
    parameter int DBIT       = 8,
    parameter int STOP_BITS  = 1,
    parameter int TIMER_BITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TIMER_BITS-1:0] baud_final,
    input  logic                  tx_start,
    input  logic [DBIT-1:0]       tx_din,
    output logic                  tx_busy,
    output logic                  tx_done_tick,
    output logic                  tx
);

    localparam int IDX_W = $clog2(DBIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q;
    logic [TIMER_BITS-1:0] cnt_q;
    logic [TIMER_BITS-1:0] bp_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DBIT-1:0]       shift_q;
    logic                  stop_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q;
`endif

    logic bit_end;
    assign bit_end = (cnt_q == bp_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bp_q     <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        bp_q     <= baud_final;
                        shift_q  <= tx_din;
`ifdef UART_TX_PARITY_EN
                        // Data is shifted away during DATA, so parity is captured at acceptance.
                        parity_q <= ^tx_din;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        idx_q   <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx_q == IDX_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            stop_q  <= 1'b0;
`endif
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop_q == 1'(STOP_BITS - 1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed vector table, reset-abort sequence and
// randomized frames compared cycle by cycle against a bit-list model of the frame.
module tb_uart_tx_ctrl;

    localparam int DBIT       = 8;
    localparam int STOP_BITS  = 1;
    localparam int TIMER_BITS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [TIMER_BITS-1:0] baud_final = '0;
    logic                  tx_start = 1'b0;
    logic [DBIT-1:0]       tx_din = '0;
    logic                  tx_busy;
    logic                  tx_done_tick;
    logic                  tx;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_ctrl #(.DBIT(DBIT), .STOP_BITS(STOP_BITS), .TIMER_BITS(TIMER_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_final  (baud_final),
        .tx_start    (tx_start),
        .tx_din      (tx_din),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        int         bp;
        int         exp_len;
        bit         hold;
        bit         disturb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame as a list of line levels, one entry per bit period.
    function automatic void build_frame(input logic [7:0] din, output bit bits[$]);
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < DBIT; i++) bits.push_back(din[i]);
        if (PAR == 1) bits.push_back(^din);
        for (int s = 0; s < STOP_BITS; s++) bits.push_back(1'b1);
    endfunction

    task automatic send_frame(input logic [7:0] din, input int bp, input int exp_len,
                              input bit hold, input bit disturb, input bit noise);
        bit bits[$];
        int L;
        int busy_cnt;
        build_frame(din, bits);
        L = bits.size() * (bp + 1);
        busy_cnt = 0;
        tx_start   = 1'b1;
        tx_din     = din;
        baud_final = TIMER_BITS'(bp);
        step();
        if (!hold) tx_start = 1'b0;
        for (int k = 0; k <= L; k++) begin
            if (tx_busy) busy_cnt++;
            if (k < L) begin
                chk($sformatf("tx din=%0h bp=%0d k=%0d", din, bp, k), tx, bits[k / (bp + 1)]);
                chk($sformatf("busy din=%0h k=%0d", din, k), tx_busy, 1);
                chk($sformatf("done_early din=%0h k=%0d", din, k), tx_done_tick, 0);
                if (disturb && k == 12) begin
                    tx_start = 1'b1; tx_din = 8'h00; baud_final = 10'd7;
                end else if (disturb && k == 13) begin
                    tx_start = hold;
                end
                if (noise) begin
                    tx_start   = 1'($urandom);
                    tx_din     = 8'($urandom);
                    baud_final = TIMER_BITS'($urandom_range(0, 1023));
                end
                step();
            end else begin
                chk($sformatf("done din=%0h", din), tx_done_tick, 1);
                chk($sformatf("busy_end din=%0h", din), tx_busy, 0);
                chk($sformatf("tx_end din=%0h", din), tx, 1);
                chk($sformatf("frame_len din=%0h bp=%0d", din, bp), busy_cnt, exp_len);
                tx_start = hold;
            end
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("idle_tx i=%0d", i), tx, 1);
            chk($sformatf("idle_busy i=%0d", i), tx_busy, 0);
            chk($sformatf("idle_done i=%0d", i), tx_done_tick, 0);
        end
    endtask

    initial begin
        bit bits[$];
        vecs[0] = '{8'hA5, 3, 40, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 0, 10, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 1, 20, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1, 20, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 3, 40, 1'b0, 1'b1};
        vecs[5] = '{8'h3C, 2, 30, 1'b0, 1'b0};

        reset = 1'b0;
        tx_start = 1'b1;
        step();
        step();
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done_tick, 0);
        tx_start = 1'b0;
        reset = 1'b1;
        idle_check(3);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].din, vecs[v].bp, vecs[v].exp_len + PAR * (vecs[v].bp + 1),
                       vecs[v].hold, vecs[v].disturb, 1'b0);
            if (!vecs[v].hold) idle_check(2);
        end

        // Reset at cycle 15 of a frame aborts it without a done tick.
        build_frame(8'hC3, bits);
        tx_start = 1'b1; tx_din = 8'hC3; baud_final = 10'd3;
        step();
        tx_start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("abort_tx k=%0d", k), tx, bits[k / 4]);
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_tx_high", tx, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_done", tx_done_tick, 0);
        idle_check(40);
        send_frame(8'h96, 3, 40 + PAR * 4, 1'b0, 1'b0, 1'b0);
        idle_check(1);

        for (int r = 0; r < 20; r++) begin
            logic [7:0] d;
            int bp;
            d  = 8'($urandom);
            bp = $urandom_range(0, 5);
            send_frame(d, bp, (1 + DBIT + PAR + STOP_BITS) * (bp + 1), 1'b0, 1'b0, 1'b1);
            idle_check($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
